// File: rtl/face_pkg.sv
// Shared face definitions: face codes, FSM states and the 8x8 bitmaps
// used by both the sequencer and the row scanner.
package face_pkg;

  typedef enum logic [1:0] {
    FACE_NEUTRAL = 2'd0,
    FACE_LAUGH   = 2'd1,
    FACE_CRY     = 2'd2,
    FACE_BLANK   = 2'd3
  } face_e;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_IDLE = 2'd3
  } state_e;

  // Element 0 is the top row.
  typedef logic [0:7][7:0] bitmap_t;

  localparam bitmap_t BMP_NEUTRAL = {8'h00, 8'h66, 8'h66, 8'h66, 8'h00, 8'h00, 8'h7E, 8'h00};
  localparam bitmap_t BMP_LAUGH   = {8'h00, 8'h66, 8'h66, 8'h66, 8'h00, 8'h42, 8'h24, 8'h18};
  localparam bitmap_t BMP_CRY     = {8'h00, 8'h66, 8'h66, 8'h66, 8'h00, 8'h18, 8'h24, 8'h42};
  localparam bitmap_t BMP_BLANK   = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  function automatic bitmap_t face_bitmap(input face_e f);
    case (f)
      FACE_NEUTRAL: face_bitmap = BMP_NEUTRAL;
      FACE_LAUGH:   face_bitmap = BMP_LAUGH;
      FACE_CRY:     face_bitmap = BMP_CRY;
      default:      face_bitmap = BMP_BLANK;
    endcase
  endfunction

  // Event priority rank: exploded (cry) > defused (laugh) > clear (neutral).
  function automatic logic [1:0] face_rank(input face_e f);
    case (f)
      FACE_CRY:   face_rank = 2'd2;
      FACE_LAUGH: face_rank = 2'd1;
      default:    face_rank = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/face_row_loader.sv
// Streams the eight rows of a bitmap over a valid/ready handshake and
// pulses done in the cycle row 7 is accepted.
module face_row_loader
  import face_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  bitmap_t    bitmap,
  input  logic       row_ready,
  output logic       row_valid,
  output logic [2:0] row_idx,
  output logic [7:0] row_data,
  output logic       done
);

  logic [2:0] next_idx_s;

  assign next_idx_s = row_idx + 3'd1;
  assign done       = row_valid && row_ready && (row_idx == 3'd7);

  // Row counter and output registers; rows hold steady while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_valid <= 1'b0;
      row_idx   <= 3'd0;
      row_data  <= 8'h00;
    end else if (start) begin
      row_valid <= 1'b1;
      row_idx   <= 3'd0;
      row_data  <= bitmap[0];
    end else if (row_valid && row_ready) begin
      if (row_idx == 3'd7) begin
        row_valid <= 1'b0;
      end else begin
        row_idx  <= next_idx_s;
        row_data <= bitmap[next_idx_s];
      end
    end
  end

endmodule

// File: rtl/face_sequencer.sv
// Turns game-outcome events into timed face animations and feeds the
// selected bitmap to the LED scanner one row at a time.
module face_sequencer
  import face_pkg::*;
#(
  parameter int unsigned HOLD_TICKS  = 40,
  parameter int unsigned BLINK_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       defused,
  input  logic       exploded,
  input  logic       clear,
  input  logic       row_ready,
  output logic       row_valid,
  output logic [2:0] row_idx,
  output logic [7:0] row_data,
  output logic [1:0] face_id,
  output logic       busy
);

  localparam logic [15:0] HOLD_LIM  = 16'(HOLD_TICKS);
  localparam logic [15:0] BLINK_LIM = 16'(BLINK_TICKS);

  state_e      state_r, state_nx;
  face_e       face_r, face_nx, pend_f_r, pend_f_nx, ev_face_s, merge_f_s;
  logic [15:0] hold_cnt_r, hold_nx, blink_cnt_r, blink_nx, hold_inc_s, blink_inc_s;
  logic        pend_v_r, pend_v_nx, merge_v_s, ev_s;
  logic        go_r, go_nx, blink_load_r, blink_load_nx, expired_r, expired_nx;
  logic        expire_now_s, done_s, busy_r;
  bitmap_t     bmp_s;

  assign bmp_s       = face_bitmap(face_r);
  assign hold_inc_s  = hold_cnt_r + 16'd1;
  assign blink_inc_s = blink_cnt_r + 16'd1;
  assign face_id     = face_r;
  assign busy        = busy_r;

  // Event arbitration and merge into the single pending slot
  always_comb begin
    ev_s      = exploded || defused || clear;
    ev_face_s = exploded ? FACE_CRY : (defused ? FACE_LAUGH : FACE_NEUTRAL);
    if (ev_s && (!pend_v_r || (face_rank(ev_face_s) >= face_rank(pend_f_r)))) begin
      merge_v_s = 1'b1;
      merge_f_s = ev_face_s;
    end else begin
      merge_v_s = pend_v_r;
      merge_f_s = pend_f_r;
    end
    // A hold that runs out during a blink reload is honoured after that frame.
    expire_now_s = expired_r || (blink_load_r && tick && (hold_inc_s == HOLD_LIM));
  end

  // Next-state and counter logic
  always_comb begin
    state_nx      = state_r;
    face_nx       = face_r;
    hold_nx       = hold_cnt_r;
    blink_nx      = blink_cnt_r;
    pend_v_nx     = pend_v_r;
    pend_f_nx     = pend_f_r;
    blink_load_nx = blink_load_r;
    expired_nx    = expired_r;
    go_nx         = 1'b0;
    case (state_r)
      ST_INIT: begin
        state_nx  = ST_LOAD;
        face_nx   = FACE_NEUTRAL;
        go_nx     = 1'b1;
        pend_v_nx = merge_v_s;
        pend_f_nx = merge_f_s;
      end
      ST_LOAD: begin
        if (blink_load_r && tick) begin
          hold_nx  = hold_inc_s;
          blink_nx = (blink_inc_s == BLINK_LIM) ? 16'd0 : blink_inc_s;
        end else begin
          hold_nx  = hold_cnt_r;
          blink_nx = blink_cnt_r;
        end
        expired_nx = expire_now_s;
        if (done_s) begin
          expired_nx    = 1'b0;
          blink_load_nx = 1'b0;
          pend_v_nx     = 1'b0;
          if (merge_v_s) begin
            state_nx = ST_LOAD;
            face_nx  = merge_f_s;
            hold_nx  = 16'd0;
            blink_nx = 16'd0;
            go_nx    = 1'b1;
          end else if (expire_now_s) begin
            state_nx = ST_LOAD;
            face_nx  = FACE_NEUTRAL;
            hold_nx  = 16'd0;
            blink_nx = 16'd0;
            go_nx    = 1'b1;
          end else if (face_r == FACE_NEUTRAL) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_HOLD;
          end
        end else begin
          pend_v_nx = merge_v_s;
          pend_f_nx = merge_f_s;
        end
      end
      ST_HOLD: begin
        if (ev_s) begin
          state_nx      = ST_LOAD;
          face_nx       = ev_face_s;
          hold_nx       = 16'd0;
          blink_nx      = 16'd0;
          blink_load_nx = 1'b0;
          go_nx         = 1'b1;
        end else if (tick) begin
          if (hold_inc_s == HOLD_LIM) begin
            state_nx      = ST_LOAD;
            face_nx       = FACE_NEUTRAL;
            hold_nx       = 16'd0;
            blink_nx      = 16'd0;
            blink_load_nx = 1'b0;
            go_nx         = 1'b1;
          end else if (((face_r == FACE_CRY) || (face_r == FACE_BLANK)) &&
                       (blink_inc_s == BLINK_LIM)) begin
            state_nx      = ST_LOAD;
            face_nx       = (face_r == FACE_CRY) ? FACE_BLANK : FACE_CRY;
            hold_nx       = hold_inc_s;
            blink_nx      = 16'd0;
            blink_load_nx = 1'b1;
            go_nx         = 1'b1;
          end else begin
            hold_nx  = hold_inc_s;
            blink_nx = blink_inc_s;
          end
        end else begin
          state_nx = ST_HOLD;
        end
      end
      ST_IDLE: begin
        if (ev_s) begin
          state_nx      = ST_LOAD;
          face_nx       = ev_face_s;
          hold_nx       = 16'd0;
          blink_nx      = 16'd0;
          blink_load_nx = 1'b0;
          go_nx         = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_INIT;
      end
    endcase
  end

  // State, counters, pending event and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_INIT;
      face_r       <= FACE_NEUTRAL;
      hold_cnt_r   <= 16'd0;
      blink_cnt_r  <= 16'd0;
      pend_v_r     <= 1'b0;
      pend_f_r     <= FACE_NEUTRAL;
      blink_load_r <= 1'b0;
      expired_r    <= 1'b0;
      go_r         <= 1'b0;
      busy_r       <= 1'b1;
    end else begin
      state_r      <= state_nx;
      face_r       <= face_nx;
      hold_cnt_r   <= hold_nx;
      blink_cnt_r  <= blink_nx;
      pend_v_r     <= pend_v_nx;
      pend_f_r     <= pend_f_nx;
      blink_load_r <= blink_load_nx;
      expired_r    <= expired_nx;
      go_r         <= go_nx;
      busy_r       <= (state_nx != ST_IDLE);
    end
  end

  face_row_loader u_loader (
    .clk       (clk),
    .rst       (rst),
    .start     (go_r),
    .bitmap    (bmp_s),
    .row_ready (row_ready),
    .row_valid (row_valid),
    .row_idx   (row_idx),
    .row_data  (row_data),
    .done      (done_s)
  );

endmodule

// File: tb/tb_face_sequencer.sv
// Scoreboard bench for face_sequencer: expected rows are queued as stimulus
// is issued and a monitor compares every accepted row against the queue.
module tb_face_sequencer;

  logic       clk = 1'b0;
  logic       rst, tick, defused, exploded, clear, row_ready;
  logic       row_valid, busy;
  logic [2:0] row_idx;
  logic [7:0] row_data;
  logic [1:0] face_id;

  int checks = 0;
  int errors = 0;
  int gap_chk = 0;

  typedef struct packed {
    logic [1:0] face;
    logic [2:0] idx;
    logic [7:0] data;
  } row_t;
  row_t sb_q[$];

  localparam logic [7:0] TBL [0:3][0:7] = '{
    '{8'h00, 8'h66, 8'h66, 8'h66, 8'h00, 8'h00, 8'h7E, 8'h00},
    '{8'h00, 8'h66, 8'h66, 8'h66, 8'h00, 8'h42, 8'h24, 8'h18},
    '{8'h00, 8'h66, 8'h66, 8'h66, 8'h00, 8'h18, 8'h24, 8'h42},
    '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}
  };

  localparam logic [3:0] M_TICK = 4'b1000;
  localparam logic [3:0] M_EXP  = 4'b0100;
  localparam logic [3:0] M_DEF  = 4'b0010;
  localparam logic [3:0] M_CLR  = 4'b0001;

  face_sequencer #(.HOLD_TICKS(10), .BLINK_TICKS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .defused   (defused),
    .exploded  (exploded),
    .clear     (clear),
    .row_ready (row_ready),
    .row_valid (row_valid),
    .row_idx   (row_idx),
    .row_data  (row_data),
    .face_id   (face_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [1:0] f);
    for (int r = 0; r < 8; r++) begin
      sb_q.push_back({f, 3'(r), TBL[f][r]});
    end
  endtask

  task automatic pulse(input logic [3:0] m);
    @(posedge clk); #1;
    {tick, exploded, defused, clear} = m;
    @(posedge clk); #1;
    {tick, exploded, defused, clear} = 4'b0000;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!busy) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle: busy still %0b after %0d cycles", busy, budget);
  endtask

  task automatic wait_row(input logic [2:0] idx, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (row_valid && (row_idx == idx)) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_row: row %0d never presented within %0d cycles", idx, budget);
  endtask

  task automatic monitor();
    int   ncyc = 0;
    int   last_xfer = 0;
    row_t exp_row;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst && row_valid && row_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL row_unexpected: got face %0d row %0d data %0h, nothing expected",
                   face_id, row_idx, row_data);
        end else begin
          exp_row = sb_q.pop_front();
          chk("row_xfer", {19'd0, face_id, row_idx, row_data}, {19'd0, exp_row});
        end
        if ((row_idx == 3'd0) && (gap_chk != 0)) begin
          chk("pending_gap", 32'(ncyc - last_xfer), 32'd2);
          gap_chk = 0;
        end
        last_xfer = ncyc;
      end
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; defused = 1'b0; exploded = 1'b0; clear = 1'b0; row_ready = 1'b1;
    fork
      monitor();
    join_none

    // Reset values
    #3;
    chk("rst_valid", {31'd0, row_valid}, 32'd0);
    chk("rst_idx", {29'd0, row_idx}, 32'd0);
    chk("rst_data", {24'd0, row_data}, 32'd0);
    chk("rst_face", {30'd0, face_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);

    // Neutral frame after reset release
    push_frame(2'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_idle(100);
    chk("init_face", {30'd0, face_id}, 32'd0);
    chk("init_busy", {31'd0, busy}, 32'd0);

    // Laugh with a 3-cycle stall at row 4, then hold expiry back to neutral
    push_frame(2'd1);
    pulse(M_DEF);
    wait_row(3'd4, 50);
    row_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_idx", {29'd0, row_idx}, 32'd4);
      chk("stall_data", {24'd0, row_data}, 32'h00);
      chk("stall_valid", {31'd0, row_valid}, 32'd1);
    end
    row_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("laugh_face", {30'd0, face_id}, 32'd1);
    chk("laugh_busy", {31'd0, busy}, 32'd1);
    for (int t = 1; t <= 10; t++) begin
      if (t == 10) push_frame(2'd0);
      pulse(M_TICK);
      repeat (12) @(posedge clk);
      #1;
      if (t == 9) chk("laugh_t9_face", {30'd0, face_id}, 32'd1);
    end
    wait_idle(100);
    chk("laugh_end_face", {30'd0, face_id}, 32'd0);

    // Crying with blink every 3 ticks, neutral at tick 10
    push_frame(2'd2);
    pulse(M_EXP);
    repeat (12) @(posedge clk);
    for (int t = 1; t <= 10; t++) begin
      logic [1:0] ef;
      if (t < 3) ef = 2'd2;
      else if (t < 6) ef = 2'd3;
      else if (t < 9) ef = 2'd2;
      else if (t < 10) ef = 2'd3;
      else ef = 2'd0;
      if (t == 3 || t == 6 || t == 9 || t == 10) push_frame(ef);
      pulse(M_TICK);
      repeat (12) @(posedge clk);
      #1;
      chk("blink_face", {30'd0, face_id}, {30'd0, ef});
    end
    wait_idle(100);

    // Simultaneous defused+exploded during a load: cry follows back-to-back
    push_frame(2'd0);
    pulse(M_CLR);
    wait_row(3'd2, 50);
    push_frame(2'd2);
    gap_chk = 1;
    pulse(M_EXP | M_DEF);
    repeat (20) @(posedge clk);
    #1;
    chk("pend_face", {30'd0, face_id}, 32'd2);
    chk("pend_busy", {31'd0, busy}, 32'd1);
    push_frame(2'd0);
    pulse(M_CLR);
    wait_idle(100);

    // Reset in the middle of a load
    push_frame(2'd1);
    pulse(M_DEF);
    wait_row(3'd3, 50);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, row_valid}, 32'd0);
    chk("mid_rst_idx", {29'd0, row_idx}, 32'd0);
    chk("mid_rst_face", {30'd0, face_id}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd1);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    push_frame(2'd0);
    rst = 1'b0;
    wait_idle(100);
    chk("post_rst_face", {30'd0, face_id}, 32'd0);
    repeat (5) @(posedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
